dla_xbar_config_loader: RTL and testbench



---
 rtl/dla_xbar_pkg.sv | 29 ++
 rtl/dla_xbar_config_pkt_fifo.sv | 72 +++++++
 rtl/dla_xbar_config_loader.sv | 149 ++++++++++++++
 tb/tb_dla_xbar_config_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dla_xbar_pkg.sv
// Shared types for the aux-kernel crossbar config path: assembler
// state encoding, consumer-side packet view and beat slice helper.
package dla_xbar_pkg;

    localparam int unsigned XBAR_CFG_DW    = 32;
    localparam int unsigned XBAR_CFG_BEATS = 4;

    // Consumer-side view of a default-sized packet; beat0 is the LSBs.
    typedef struct packed {
        logic [XBAR_CFG_DW-1:0] beat3;
        logic [XBAR_CFG_DW-1:0] beat2;
        logic [XBAR_CFG_DW-1:0] beat1;
        logic [XBAR_CFG_DW-1:0] beat0;
    } xbar_cfg_pkt_t;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_DISCARD = 1'b1
    } asm_state_e;

    // Bit offset of beat 'idx' inside a packet of 'dw'-bit beats.
    function automatic int unsigned beat_offset(
        input int unsigned idx,
        input int unsigned dw
    );
        return idx * dw;
    endfunction

endpackage

// File: rtl/dla_xbar_config_pkt_fifo.sv
// DEPTH x WIDTH register FIFO, first-word fall-through head.
// Ports: clk, i_sclr, i_push/i_data, i_pop, o_head, o_count, o_full, o_empty.
module dla_xbar_config_pkt_fifo
    import dla_xbar_pkg::*;
#(
    parameter  int unsigned WIDTH = 128,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned     PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dla_xbar_config_loader.sv
// Assembles config beats into packets and queues them for the xbar FSM.
// Ports: clk, i_sclr, cfg beat stream in (valid/ready/data/last),
// packet stream out (valid/ready/data), o_pkt_count, o_beat_count, o_error.
// Optional: DLA_XBAR_CONFIG_LOADER_FRAME_CHECK_EN enables i_cfg_last
// framing check, the S_DISCARD state and the sticky o_error flag.
module dla_xbar_config_loader
    import dla_xbar_pkg::*;
#(
    parameter  int unsigned CONFIG_DATA_WIDTH = 32,
    parameter  int unsigned CONFIG_BEAT_COUNT = 4,
    parameter  int unsigned PKT_DEPTH         = 2,
    localparam int unsigned PKT_WIDTH = CONFIG_DATA_WIDTH * CONFIG_BEAT_COUNT,
    localparam int unsigned CNT_W     = $clog2(PKT_DEPTH + 1),
    localparam int unsigned BEAT_W    = $clog2(CONFIG_BEAT_COUNT + 1)
) (
    input  logic                         clk,
    input  logic                         i_sclr,
    input  logic                         i_cfg_valid,
    input  logic [CONFIG_DATA_WIDTH-1:0] i_cfg_data,
    input  logic                         i_cfg_last,
    output logic                         o_cfg_ready,
    output logic                         o_pkt_valid,
    output logic [PKT_WIDTH-1:0]         o_pkt_data,
    input  logic                         i_pkt_ready,
    output logic [CNT_W-1:0]             o_pkt_count,
    output logic [BEAT_W-1:0]            o_beat_count,
    output logic                         o_error
);

    localparam int unsigned     DW       = CONFIG_DATA_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(CONFIG_BEAT_COUNT - 1);

    asm_state_e         state_q;
    asm_state_e         state_d;
    logic [BEAT_W-1:0]  beat_q;
    logic [BEAT_W-1:0]  beat_d;
    logic [PKT_WIDTH-1:0] stage_q;
    logic [PKT_WIDTH-1:0] stage_d;
    logic [PKT_WIDTH-1:0] push_data;
    logic               push;
    logic               pkt_full;
    logic               pkt_empty;
    logic               accept;
    logic               at_last;

    assign at_last = (beat_q == LAST_IDX);

    // Only the packet-completing beat needs a free queue slot, so
    // non-last beats keep flowing while the queue is full.
    assign o_cfg_ready  = (state_q == S_DISCARD) || !(at_last && pkt_full);
    assign accept       = i_cfg_valid && o_cfg_ready;
    assign o_beat_count = beat_q;
    assign o_pkt_valid  = !pkt_empty;

    // The final beat goes straight into the queue, bypassing staging.
    always_comb begin
        push_data = stage_q;
        push_data[beat_offset(CONFIG_BEAT_COUNT - 1, DW) +: DW] = i_cfg_data;
    end

`ifdef DLA_XBAR_CONFIG_LOADER_FRAME_CHECK_EN
    logic err_q;
    logic err_d;
    assign o_error = err_q;
`else
    logic unused_cfg_last;
    assign unused_cfg_last = i_cfg_last;
    assign o_error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        stage_d = stage_q;
        push    = 1'b0;
`ifdef DLA_XBAR_CONFIG_LOADER_FRAME_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_COLLECT: begin
                if (accept) begin
`ifdef DLA_XBAR_CONFIG_LOADER_FRAME_CHECK_EN
                    if (i_cfg_last != at_last) begin
                        // Early last or missing last: drop the frame.
                        beat_d = '0;
                        err_d  = 1'b1;
                        if (at_last) begin
                            state_d = S_DISCARD;
                        end
                    end else
`endif
                    if (at_last) begin
                        push   = 1'b1;
                        beat_d = '0;
                    end else begin
                        stage_d[beat_offset(int'(beat_q), DW) +: DW] = i_cfg_data;
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
`ifdef DLA_XBAR_CONFIG_LOADER_FRAME_CHECK_EN
            S_DISCARD: begin
                if (accept && i_cfg_last) begin
                    state_d = S_COLLECT;
                    beat_d  = '0;
                end
            end
`endif
            default: begin
                state_d = S_COLLECT;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_q <= S_COLLECT;
            beat_q  <= '0;
            stage_q <= '0;
`ifdef DLA_XBAR_CONFIG_LOADER_FRAME_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            stage_q <= stage_d;
`ifdef DLA_XBAR_CONFIG_LOADER_FRAME_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    dla_xbar_config_pkt_fifo #(
        .WIDTH (PKT_WIDTH),
        .DEPTH (PKT_DEPTH)
    ) u_pkt_fifo (
        .clk     (clk),
        .i_sclr  (i_sclr),
        .i_push  (push),
        .i_data  (push_data),
        .i_pop   (i_pkt_ready),
        .o_head  (o_pkt_data),
        .o_count (o_pkt_count),
        .o_full  (pkt_full),
        .o_empty (pkt_empty)
    );

endmodule

// File: tb/tb_dla_xbar_config_loader.sv
// Scoreboard bench for dla_xbar_config_loader: default 32x4x2 instance
// plus a 1-beat, 1-deep instance.
module tb_dla_xbar_config_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         sclr;
    logic         v0, l0, pr0;
    logic [31:0]  d0;
    logic         r0, pv0, err0;
    logic [127:0] pd0;
    logic [1:0]   pc0;
    logic [2:0]   bc0;

    logic         v1, l1, pr1;
    logic [31:0]  d1;
    logic         r1, pv1, err1;
    logic [31:0]  pd1;
    logic [0:0]   pc1;
    logic [0:0]   bc1;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;
    bit stream   = 1'b0;

    logic [127:0] exp0_q[$];
    logic [31:0]  exp1_q[$];

    dla_xbar_config_loader u_dut0 (
        .clk          (clk),
        .i_sclr       (sclr),
        .i_cfg_valid  (v0),
        .i_cfg_data   (d0),
        .i_cfg_last   (l0),
        .o_cfg_ready  (r0),
        .o_pkt_valid  (pv0),
        .o_pkt_data   (pd0),
        .i_pkt_ready  (pr0),
        .o_pkt_count  (pc0),
        .o_beat_count (bc0),
        .o_error      (err0)
    );

    dla_xbar_config_loader #(
        .CONFIG_DATA_WIDTH (32),
        .CONFIG_BEAT_COUNT (1),
        .PKT_DEPTH         (1)
    ) u_dut1 (
        .clk          (clk),
        .i_sclr       (sclr),
        .i_cfg_valid  (v1),
        .i_cfg_data   (d1),
        .i_cfg_last   (l1),
        .o_cfg_ready  (r1),
        .o_pkt_valid  (pv1),
        .o_pkt_data   (pd1),
        .i_pkt_ready  (pr1),
        .o_pkt_count  (pc1),
        .o_beat_count (bc1),
        .o_error      (err1)
    );

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard whenever a packet handshake will
    // complete at the coming edge.
    always @(negedge clk) begin
        if (!sclr && pv0 && pr0) begin
            if (exp0_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pkt0_unexpected: got %h expected none", pd0);
            end else begin
                check("pkt0_data", pd0, exp0_q.pop_front());
            end
        end
        if (!sclr && pv1 && pr1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pkt1_unexpected: got %h expected none", pd1);
            end else begin
                check("pkt1_data", {96'd0, pd1}, {96'd0, exp1_q.pop_front()});
            end
        end
        if (stream && v0 && !r0) stalls++;
    end

    task automatic send0(input logic [31:0] d, input logic last);
        int n = 0;
        v0 = 1'b1;
        d0 = d;
        l0 = last;
        @(negedge clk);
        while (!r0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!r0) begin
            checks++;
            failures++;
            $display("FAIL beat0_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        l0 = 1'b0;
    endtask

    task automatic send_pkt0(input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3);
        exp0_q.push_back({b3, b2, b1, b0});
        send0(b0, 1'b0);
        send0(b1, 1'b0);
        send0(b2, 1'b0);
        send0(b3, 1'b1);
    endtask

    task automatic drain0();
        int n = 0;
        while (exp0_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (exp0_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain0_timeout: got %0d left expected 0",
                     exp0_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sclr = 1'b1;
        v0 = 1'b0; l0 = 1'b0; pr0 = 1'b0; d0 = '0;
        v1 = 1'b0; l1 = 1'b0; pr1 = 1'b0; d1 = '0;
        repeat (2) @(posedge clk);
        #1;
        sclr = 1'b0;

        // Reset state.
        check("rst_ready", r0, 1);
        check("rst_valid", pv0, 0);
        check("rst_count", pc0, 0);
        check("rst_beats", bc0, 0);
        check("rst_error", err0, 0);
        check("rst_data", pd0, 0);
        check("rst1_ready", r1, 1);
        check("rst1_valid", pv1, 0);

        // Two packets back-to-back with consumer stalled.
        exp0_q.push_back(128'h00000044_00000033_00000022_00000011);
        send0(32'h11, 1'b0);
        send0(32'h22, 1'b0);
        send0(32'h33, 1'b0);
        check("p1_valid_before_last", pv0, 0);
        check("p1_beats3", bc0, 3);
        send0(32'h44, 1'b1);
        check("p1_valid_latency", pv0, 1);
        check("p1_head", pd0, 128'h00000044_00000033_00000022_00000011);
        check("p1_count", pc0, 1);
        check("p1_beats0", bc0, 0);
        send_pkt0(32'h55, 32'h66, 32'h77, 32'h88);
        check("p2_count", pc0, 2);
        check("p2_head_held", pd0, 128'h00000044_00000033_00000022_00000011);

        // Full queue with the completing beat pending.
        exp0_q.push_back(128'h000000cc_000000bb_000000aa_00000099);
        send0(32'h99, 1'b0);
        send0(32'haa, 1'b0);
        send0(32'hbb, 1'b0);
        check("full_beats3", bc0, 3);
        check("full_ready_low", r0, 0);
        v0 = 1'b1; d0 = 32'hcc; l0 = 1'b1;
        pr0 = 1'b1;
        @(posedge clk);
        #1;
        pr0 = 1'b0;
        check("pop_ready_rise", r0, 1);
        check("pop_count", pc0, 1);
        @(posedge clk);
        #1;
        v0 = 1'b0; l0 = 1'b0;
        check("refill_count", pc0, 2);
        check("refill_beats", bc0, 0);

        // Continuous stream with the consumer always ready.
        pr0 = 1'b1;
        stream = 1'b1;
        send_pkt0(32'h40, 32'h41, 32'h42, 32'h43);
        send_pkt0(32'h50, 32'h51, 32'h52, 32'h53);
        send_pkt0(32'h60, 32'h61, 32'h62, 32'h63);
        stream = 1'b0;
        drain0();
        check("stream_stalls", stalls, 0);
        check("stream_empty", pv0, 0);
        pr0 = 1'b0;

        // Reset mid-packet with one packet queued.
        send_pkt0(32'h70, 32'h71, 32'h72, 32'h73);
        send0(32'h80, 1'b0);
        send0(32'h81, 1'b0);
        check("pre_sclr_beats", bc0, 2);
        sclr = 1'b1;
        exp0_q.delete();
        @(posedge clk);
        #1;
        sclr = 1'b0;
        check("sclr_valid", pv0, 0);
        check("sclr_beats", bc0, 0);
        check("sclr_count", pc0, 0);
        check("sclr_ready", r0, 1);
        send_pkt0(32'h90, 32'h91, 32'h92, 32'h93);
        check("post_sclr_head", pd0, 128'h00000093_00000092_00000091_00000090);
        pr0 = 1'b1;
        drain0();
        pr0 = 1'b0;

`ifdef DLA_XBAR_CONFIG_LOADER_FRAME_CHECK_EN
        // Early last, then missing last, then a clean packet.
        send0(32'ha0, 1'b0);
        send0(32'ha1, 1'b1);
        check("early_last_error", err0, 1);
        check("early_last_beats", bc0, 0);
        check("early_last_count", pc0, 0);
        send0(32'hb0, 1'b0);
        send0(32'hb1, 1'b0);
        send0(32'hb2, 1'b0);
        send0(32'hb3, 1'b0);
        check("no_last_count", pc0, 0);
        send0(32'hc0, 1'b0);
        send0(32'hc1, 1'b1);
        check("discard_count", pc0, 0);
        check("discard_beats", bc0, 0);
        send_pkt0(32'hd0, 32'hd1, 32'hd2, 32'hd3);
        check("recover_count", pc0, 1);
        check("error_sticky", err0, 1);
        pr0 = 1'b1;
        drain0();
        pr0 = 1'b0;
`else
        // Without the check, i_cfg_last is ignored entirely.
        exp0_q.push_back(128'h000000a3_000000a2_000000a1_000000a0);
        send0(32'ha0, 1'b0);
        send0(32'ha1, 1'b1);
        check("nochk_beats", bc0, 2);
        send0(32'ha2, 1'b0);
        send0(32'ha3, 1'b0);
        check("nochk_count", pc0, 1);
        check("nochk_error", err0, 0);
        pr0 = 1'b1;
        drain0();
        pr0 = 1'b0;
`endif

        // Single-beat packets, single-entry queue.
        exp1_q.push_back(32'ha5);
        v1 = 1'b1; d1 = 32'ha5;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        check("b1_valid", pv1, 1);
        check("b1_data", pd1, 32'ha5);
        check("b1_ready_full", r1, 0);
        check("b1_count", pc1, 1);
        exp1_q.push_back(32'h5a);
        v1 = 1'b1; d1 = 32'h5a;
        pr1 = 1'b1;
        @(negedge clk);
        check("b1_ready_no_bypass", r1, 0);
        @(posedge clk);
        #1;
        pr1 = 1'b0;
        check("b1_pop_ready", r1, 1);
        check("b1_pop_valid", pv1, 0);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        check("b1_second_valid", pv1, 1);
        check("b1_second_data", pd1, 32'h5a);
        pr1 = 1'b1;
        @(posedge clk);
        #1;
        pr1 = 1'b0;
        check("b1_empty", pv1, 0);

        check("sb0_empty", exp0_q.size(), 0);
        check("sb1_empty", exp1_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
